onchip_ram_dp_avmm: RTL and testbench

Parametrised dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on a single clock. It generalises the single-port, 4-word, 32-bit RAM to configurable width and depth. It adds true dual-port access, pipelined reads of latency 1 or 2 with readdatavalid, and deterministic collision handling. It sits on the SoC interconnect as program/data memory, or as a shared buffer between the CPU and a peripheral master.

---
 rtl/onchip_ram_dp_avmm_pkg.sv | 22 ++
 rtl/onchip_ram_dp_avmm_if.sv | 27 ++
 rtl/onchip_ram_dp_core.sv | 68 ++++++
 rtl/onchip_ram_dp_avmm.sv | 112 +++++++++++
 tb/tb_onchip_ram_dp_avmm.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_ram_dp_avmm_pkg.sv
// Shared types and helpers for the dual-port Avalon-MM on-chip RAM.
package onchip_ram_dp_avmm_pkg;

    // Mixed-port read-during-write behaviour of the array.
    typedef enum logic {
        RDW_OLD_DATA = 1'b0,
        RDW_NEW_DATA = 1'b1
    } rdw_mode_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    // Number of read pipeline stages actually built for a requested latency.
    function automatic int latency_stages(input int read_latency);
        return (read_latency >= READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY_MIN;
    endfunction

endpackage

// File: rtl/onchip_ram_dp_avmm_if.sv
// One Avalon-MM slave port of the dual-port RAM (no waitrequest).
interface onchip_ram_dp_avmm_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    import onchip_ram_dp_avmm_pkg::*;

    logic [ADDR_W-1:0]           address;
    logic                        chipselect;
    logic                        read;
    logic                        write;
    logic [bytes_of(DATA_W)-1:0] byteenable;
    logic [DATA_W-1:0]           writedata;
    logic [DATA_W-1:0]           readdata;
    logic                        readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_ram_dp_core.sv
// True-dual-port byte-enabled array: s1 wins shared lanes on dual writes,
// mixed-port read-during-write returns old data unless RDW_MODE says otherwise.
module onchip_ram_dp_core
    import onchip_ram_dp_avmm_pkg::*;
#(
    parameter int        DATA_W    = 32,
    parameter int        DEPTH     = 4096,
    parameter int        ADDR_W    = $clog2(DEPTH),
    parameter string     INIT_FILE = "",
    parameter rdw_mode_e RDW_MODE  = RDW_OLD_DATA
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr1,
    input  logic                        rd1,
    input  logic [ADDR_W-1:0]           addr1,
    input  logic [bytes_of(DATA_W)-1:0] be1,
    input  logic [DATA_W-1:0]           wdata1,
    output logic [DATA_W-1:0]           q1,
    input  logic                        wr2,
    input  logic                        rd2,
    input  logic [ADDR_W-1:0]           addr2,
    input  logic [bytes_of(DATA_W)-1:0] be2,
    input  logic [DATA_W-1:0]           wdata2,
    output logic [DATA_W-1:0]           q2
);
    localparam int NB = bytes_of(DATA_W);

    if (INIT_FILE != "") begin : g_mem
        (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];
    end else begin : g_mem
        logic [DATA_W-1:0] mem [DEPTH];
    end

    // NOTE: the array has no reset; reset clears only the read registers below.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr2 && be2[i]) g_mem.mem[addr2][8*i +: 8] <= wdata2[8*i +: 8];
            if (wr1 && be1[i]) g_mem.mem[addr1][8*i +: 8] <= wdata1[8*i +: 8];
        end
    end

    logic [DATA_W-1:0] rd_word1, rd_word2;

    // NOTE: every always_comb output gets its default first so no latch is inferred.
    always_comb begin
        rd_word1 = g_mem.mem[addr1];
        rd_word2 = g_mem.mem[addr2];
        if (RDW_MODE == RDW_NEW_DATA) begin
            for (int i = 0; i < NB; i++) begin
                if (wr2 && be2[i] && addr2 == addr1) rd_word1[8*i +: 8] = wdata2[8*i +: 8];
                if (wr1 && be1[i] && addr1 == addr2) rd_word2[8*i +: 8] = wdata1[8*i +: 8];
            end
        end
    end

    // NOTE: non-blocking updates mean a read in the write cycle sees the pre-edge word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            if (rd1) q1 <= rd_word1;
            if (rd2) q2 <= rd_word2;
        end
    end

endmodule

// File: rtl/onchip_ram_dp_avmm.sv
// Dual-port on-chip RAM with two Avalon-MM slaves: range checks, enable gating
// and read pipelines of latency 1 or 2 around the shared array.
module onchip_ram_dp_avmm
    import onchip_ram_dp_avmm_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 4096,
    parameter int    ADDR_W       = $clog2(DEPTH),
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_ram.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  reset_req,
    onchip_ram_dp_avmm_if.slave   s1,
    onchip_ram_dp_avmm_if.slave   s2
);
    localparam int               NB        = bytes_of(DATA_W);
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam bit               TWO_STAGE = (latency_stages(READ_LATENCY) == READ_LATENCY_MAX);

    logic en;
    assign en = clken & ~reset_req;

    logic [ADDR_W-1:0] addr   [2];
    logic [DATA_W-1:0] core_q [2];
    logic [DATA_W-1:0] rdata  [2];
    logic [1:0]        sel, rd_strobe, wr_strobe, wr_ok, rd_ok, rvalid;

    assign addr[0]   = s1.address;
    assign addr[1]   = s2.address;
    assign sel       = {s2.chipselect, s1.chipselect};
    assign rd_strobe = {s2.read, s1.read};
    assign wr_strobe = {s2.write, s1.write};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic              in_range, rd_acc, v1, oor1;
        logic [DATA_W-1:0] d1;

        assign in_range = {1'b0, addr[p]} < DEPTH_EXT;
        // A strobe with both read and write set is a write only.
        assign rd_acc   = en & sel[p] & rd_strobe[p] & ~wr_strobe[p];
        assign wr_ok[p] = en & sel[p] & wr_strobe[p] & in_range;
        assign rd_ok[p] = rd_acc & in_range;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v1   <= 1'b0;
                oor1 <= 1'b0;
            end else if (en) begin
                v1 <= rd_acc;
                if (rd_acc) oor1 <= ~in_range;
            end
        end

        assign d1 = oor1 ? '0 : core_q[p];

        if (TWO_STAGE) begin : g_lat2
            logic              v2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else if (en) begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end

            assign rvalid[p] = v2;
            assign rdata[p]  = d2;
        end else begin : g_lat1
            assign rvalid[p] = v1;
            assign rdata[p]  = d1;
        end
    end

    onchip_ram_dp_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE),
        .RDW_MODE  (RDW_OLD_DATA)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .wr1    (wr_ok[0]),
        .rd1    (rd_ok[0]),
        .addr1  (addr[0]),
        .be1    (s1.byteenable),
        .wdata1 (s1.writedata),
        .q1     (core_q[0]),
        .wr2    (wr_ok[1]),
        .rd2    (rd_ok[1]),
        .addr2  (addr[1]),
        .be2    (s2.byteenable),
        .wdata2 (s2.writedata),
        .q2     (core_q[1])
    );

    assign s1.readdata      = rdata[0];
    assign s1.readdatavalid = rvalid[0];
    assign s2.readdata      = rdata[1];
    assign s2.readdatavalid = rvalid[1];

    logic [NB-1:0] unused_be_width;
    assign unused_be_width = '0;

endmodule

// File: tb/tb_onchip_ram_dp_avmm.sv
// Directed bench: a 12-word latency-1 instance driven from a vector table plus
// hand sequences, and a 6-word latency-2 instance for range, latency and reset.
module tb_onchip_ram_dp_avmm;

    localparam int DW      = 32;
    localparam int M_DEPTH = 12;
    localparam int M_AW    = $clog2(M_DEPTH);
    localparam int M_LAT   = 1;
    localparam int S_DEPTH = 6;
    localparam int S_AW    = $clog2(S_DEPTH);

    logic clk = 1'b0;
    logic reset, clken, reset_req;
    always #5 clk = ~clk;

    onchip_ram_dp_avmm_if #(.DATA_W(DW), .ADDR_W(M_AW)) m1 ();
    onchip_ram_dp_avmm_if #(.DATA_W(DW), .ADDR_W(M_AW)) m2 ();
    onchip_ram_dp_avmm_if #(.DATA_W(DW), .ADDR_W(S_AW)) n1 ();
    onchip_ram_dp_avmm_if #(.DATA_W(DW), .ADDR_W(S_AW)) n2 ();

    onchip_ram_dp_avmm #(.DATA_W(DW), .DEPTH(M_DEPTH), .READ_LATENCY(M_LAT), .INIT_FILE("")) dut_main (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(m1), .s2(m2)
    );

    onchip_ram_dp_avmm #(.DATA_W(DW), .DEPTH(S_DEPTH), .READ_LATENCY(2), .INIT_FILE("")) dut_small (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(n1), .s2(n2)
    );

    typedef struct {
        string             name;
        int                port;
        bit                cs, rd, wr;
        logic [M_AW-1:0]   addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
        bit                exp_valid;
        logic [31:0]       exp_data;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int port, input bit cs, input bit rd, input bit wr,
                                input logic [M_AW-1:0] a, input logic [3:0] be, input logic [31:0] wd,
                                input bit ev, input logic [31:0] ed);
        vec_t v;
        v.name = name; v.port = port; v.cs = cs; v.rd = rd; v.wr = wr;
        v.addr = a; v.be = be; v.wdata = wd; v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle_all();
        m1.chipselect = 0; m1.read = 0; m1.write = 0; m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
        m2.chipselect = 0; m2.read = 0; m2.write = 0; m2.address = '0; m2.byteenable = '0; m2.writedata = '0;
        n1.chipselect = 0; n1.read = 0; n1.write = 0; n1.address = '0; n1.byteenable = '0; n1.writedata = '0;
        n2.chipselect = 0; n2.read = 0; n2.write = 0; n2.address = '0; n2.byteenable = '0; n2.writedata = '0;
    endtask

    task automatic drive_main(input int port, input bit cs, input bit rd, input bit wr,
                              input logic [M_AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        if (port == 1) begin
            m1.chipselect = cs; m1.read = rd; m1.write = wr; m1.address = a; m1.byteenable = be; m1.writedata = d;
        end else begin
            m2.chipselect = cs; m2.read = rd; m2.write = wr; m2.address = a; m2.byteenable = be; m2.writedata = d;
        end
    endtask

    function automatic logic main_valid(input int port);
        return (port == 1) ? m1.readdatavalid : m2.readdatavalid;
    endfunction

    function automatic logic [31:0] main_data(input int port);
        return (port == 1) ? m1.readdata : m2.readdata;
    endfunction

    // One access on the main instance, then its read result after M_LAT edges and the pulse end.
    task automatic apply_vec(input vec_t v);
        drive_main(v.port, v.cs, v.rd, v.wr, v.addr, v.be, v.wdata);
        @(posedge clk); #1;
        idle_all();
        repeat (M_LAT - 1) begin
            check({v.name, " early valid"}, main_valid(v.port), 0);
            @(posedge clk); #1;
        end
        check({v.name, " valid"}, main_valid(v.port), v.exp_valid);
        if (v.exp_valid) begin
            check({v.name, " data"}, main_data(v.port), v.exp_data);
            @(posedge clk); #1;
            check({v.name, " pulse end"}, main_valid(v.port), 0);
        end
    endtask

    task automatic small_write(input logic [S_AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        n1.chipselect = 1; n1.write = 1; n1.address = a; n1.byteenable = be; n1.writedata = d;
        @(posedge clk); #1;
        idle_all();
    endtask

    task automatic small_read(input string name, input logic [S_AW-1:0] a, input logic [31:0] exp);
        n1.chipselect = 1; n1.read = 1; n1.address = a;
        @(posedge clk); #1;
        idle_all();
        check({name, " stage1 valid"}, n1.readdatavalid, 0);
        @(posedge clk); #1;
        check({name, " valid"}, n1.readdatavalid, 1);
        check({name, " data"}, n1.readdata, exp);
        @(posedge clk); #1;
        check({name, " pulse end"}, n1.readdatavalid, 0);
    endtask

    // s2 reads of addr 0,1,2 with a three-cycle stall after the second read.
    task automatic stall_seq(input bit use_req, input string tag);
        logic [31:0] got[$];
        logic [31:0] exp[3];
        bit          en_edge;
        exp[0] = 32'h0000_00A0; exp[1] = 32'h0000_77B1; exp[2] = 32'h0022_1111;
        for (int c = 0; c < 10; c++) begin
            idle_all();
            clken = 1; reset_req = 0;
            case (c)
                0: drive_main(2, 1, 1, 0, 0, 4'h0, 32'h0);
                1: drive_main(2, 1, 1, 0, 1, 4'h0, 32'h0);
                2, 3, 4: begin
                    drive_main(2, 1, 1, 0, 3, 4'h0, 32'h0);
                    if (use_req) reset_req = 1; else clken = 0;
                end
                5: drive_main(2, 1, 1, 0, 2, 4'h0, 32'h0);
                default: ;
            endcase
            en_edge = clken & ~reset_req;
            @(posedge clk); #1;
            if (en_edge && m2.readdatavalid) got.push_back(m2.readdata);
        end
        idle_all();
        clken = 1; reset_req = 0;
        check({tag, " pulse count"}, got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("%s data %0d", tag, i), got[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        reset = 1; clken = 1; reset_req = 0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check("reset m1 valid", m1.readdatavalid, 0);
        check("reset m1 data",  m1.readdata, 0);
        check("reset m2 valid", m2.readdatavalid, 0);
        check("reset m2 data",  m2.readdata, 0);
        check("reset n1 valid", n1.readdatavalid, 0);
        check("reset n2 data",  n2.readdata, 0);
        reset = 0;
        @(posedge clk); #1;

        vecs.push_back(mk("wr a5 full",      1, 1, 0, 1,  5, 4'hF, 32'hAABB_CCDD, 0, 32'h0));
        vecs.push_back(mk("wr a5 be5",       1, 1, 0, 1,  5, 4'h5, 32'h1122_3344, 0, 32'h0));
        vecs.push_back(mk("rd a5 merged",    1, 1, 1, 0,  5, 4'h0, 32'h0,         1, 32'hAA22_CC44));
        vecs.push_back(mk("clr a9",          2, 1, 0, 1,  9, 4'hF, 32'h0,         0, 32'h0));
        vecs.push_back(mk("clr a2",          2, 1, 0, 1,  2, 4'hF, 32'h0,         0, 32'h0));
        vecs.push_back(mk("wr a0",           2, 1, 0, 1,  0, 4'hF, 32'h0000_00A0, 0, 32'h0));
        vecs.push_back(mk("wr a1",           1, 1, 0, 1,  1, 4'hF, 32'h0000_00B1, 0, 32'h0));
        vecs.push_back(mk("rd a1 cross",     2, 1, 1, 0,  1, 4'h0, 32'h0,         1, 32'h0000_00B1));
        vecs.push_back(mk("wr a3",           2, 1, 0, 1,  3, 4'hF, 32'hCAFE_F00D, 0, 32'h0));
        vecs.push_back(mk("wr a3 be0",       1, 1, 0, 1,  3, 4'h0, 32'hFFFF_FFFF, 0, 32'h0));
        vecs.push_back(mk("rd a3 be0 kept",  1, 1, 1, 0,  3, 4'h0, 32'h0,         1, 32'hCAFE_F00D));
        vecs.push_back(mk("rd+wr a4",        1, 1, 1, 1,  4, 4'hF, 32'h1234_5678, 0, 32'h0));
        vecs.push_back(mk("wr a4 no cs",     2, 0, 0, 1,  4, 4'hF, 32'hFFFF_FFFF, 0, 32'h0));
        vecs.push_back(mk("rd a4",           2, 1, 1, 0,  4, 4'h0, 32'h0,         1, 32'h1234_5678));
        vecs.push_back(mk("wr a11 last",     1, 1, 0, 1, 11, 4'hF, 32'h0BAD_C0DE, 0, 32'h0));
        vecs.push_back(mk("rd a11 last",     2, 1, 1, 0, 11, 4'h0, 32'h0,         1, 32'h0BAD_C0DE));
        vecs.push_back(mk("wr a12 oor",      1, 1, 0, 1, 12, 4'hF, 32'hFFFF_FFFF, 0, 32'h0));
        vecs.push_back(mk("rd a12 oor",      1, 1, 1, 0, 12, 4'h0, 32'h0,         1, 32'h0));
        vecs.push_back(mk("rd a11 again",    1, 1, 1, 0, 11, 4'h0, 32'h0,         1, 32'h0BAD_C0DE));
        vecs.push_back(mk("rd a15 oor",      1, 1, 1, 0, 15, 4'h0, 32'h0,         1, 32'h0));
        vecs.push_back(mk("rd no cs",        1, 0, 1, 0,  5, 4'h0, 32'h0,         0, 32'h0));
        vecs.push_back(mk("wr a1 lane1",     2, 1, 0, 1,  1, 4'h2, 32'h0000_7700, 0, 32'h0));
        vecs.push_back(mk("rd a1 lane1",     1, 1, 1, 0,  1, 4'h0, 32'h0,         1, 32'h0000_77B1));
        foreach (vecs[i]) apply_vec(vecs[i]);

        // Mixed-port collision: s2 sees old data, then the new word one cycle later.
        drive_main(1, 1, 0, 1, 9, 4'hF, 32'hDEAD_BEEF);
        drive_main(2, 1, 1, 0, 9, 4'h0, 32'h0);
        @(posedge clk); #1;
        idle_all();
        check("collision old valid", m2.readdatavalid, 1);
        check("collision old data",  m2.readdata, 32'h0);
        drive_main(2, 1, 1, 0, 9, 4'h0, 32'h0);
        @(posedge clk); #1;
        idle_all();
        check("collision new valid", m2.readdatavalid, 1);
        check("collision new data",  m2.readdata, 32'hDEAD_BEEF);

        // Dual write to addr 2: s1 wins lane 1, lane 2 from s2 only, lane 3 untouched.
        drive_main(1, 1, 0, 1, 2, 4'h3, 32'h1111_1111);
        drive_main(2, 1, 0, 1, 2, 4'h6, 32'h2222_2222);
        @(posedge clk); #1;
        idle_all();
        apply_vec(mk("dual write rd a2", 2, 1, 1, 0, 2, 4'h0, 32'h0, 1, 32'h0022_1111));

        // Read on the cycle right after a write from the other port.
        drive_main(2, 1, 0, 1, 6, 4'hF, 32'h5A5A_5A5A);
        @(posedge clk); #1;
        drive_main(2, 0, 0, 0, 0, 4'h0, 32'h0);
        drive_main(1, 1, 1, 0, 6, 4'h0, 32'h0);
        @(posedge clk); #1;
        idle_all();
        check("raw next cycle valid", m1.readdatavalid, 1);
        check("raw next cycle data",  m1.readdata, 32'h5A5A_5A5A);

        stall_seq(0, "clken stall");
        stall_seq(1, "reset_req stall");

        // Small instance: latency 2 and the out-of-range boundary.
        small_write(5, 4'hF, 32'hAABB_CCDD);
        small_write(5, 4'h5, 32'h1122_3344);
        small_write(7, 4'hF, 32'hFFFF_FFFF);
        small_read("lat2 rd a5", 5, 32'hAA22_CC44);
        small_read("lat2 rd a7 oor", 7, 32'h0);
        small_read("lat2 rd a5 again", 5, 32'hAA22_CC44);
        small_read("lat2 rd a6 oor", 6, 32'h0);

        // Reset with two reads in flight in the latency-2 pipeline.
        n1.chipselect = 1; n1.read = 1; n1.address = 5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle_all();
        check("inflight first result", n1.readdatavalid, 1);
        #2 reset = 1;
        #1;
        check("reset drops valid", n1.readdatavalid, 0);
        check("reset clears data", n1.readdata, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("no pulse after reset %0d", k), n1.readdatavalid, 0);
        end
        small_read("post reset rd a5", 5, 32'hAA22_CC44);
        apply_vec(mk("post reset main a5", 1, 1, 1, 0, 5, 4'h0, 32'h0, 1, 32'hAA22_CC44));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
